// File: rtl/axis_testpattern_checker_if.sv
`default_nettype none
// ============================================================================
// axis_testpattern_checker_if : AXI-Stream tdata/tvalid/tready bundle
// Revision: 1.0
// ============================================================================
interface axis_testpattern_checker_if #(
   parameter int TDATA_WIDTH = 32
);
   logic [TDATA_WIDTH-1:0] tdata;
   logic                   tvalid;
   logic                   tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/axis_testpattern_checker.sv
`default_nettype none
// ============================================================================
// axis_testpattern_checker : AXI-Stream sink checking a wrap-around counter
// pattern; option macro AXIS_TPCHK_RESYNC_EN re-aligns on mismatch. Rev 1.0
// ============================================================================
module axis_testpattern_checker #(
   parameter int S00_AXIS_TDATA_WIDTH = 32,
   parameter int COUNTER_START        = 0,
   parameter int COUNTER_END          = 255,
   parameter int COUNTER_INCR         = 1,
   parameter int READY_DIVIDER        = 1,
   parameter int ERRCNT_WIDTH         = 16,
   parameter int BEATCNT_WIDTH        = 32
) (
   input  wire logic                     s_axis_aclk,
   input  wire logic                     s_axis_areset,
   input  wire logic                     enable,
   input  wire logic                     clear,
   axis_testpattern_checker_if.slave     s_axis,
   output logic                          locked,
   output logic                          error,
   output logic [ERRCNT_WIDTH-1:0]       err_count,
   output logic [BEATCNT_WIDTH-1:0]      beat_count
);
   localparam int C_W     = S00_AXIS_TDATA_WIDTH;
   localparam int C_DIV_W = (READY_DIVIDER > 1) ? $clog2(READY_DIVIDER) : 1;
   localparam logic [C_W-1:0]     C_START    = C_W'(COUNTER_START);
   localparam logic [C_W:0]       C_END_EXT  = (C_W+1)'(COUNTER_END);
   localparam logic [C_W:0]       C_INCR_EXT = (C_W+1)'(COUNTER_INCR);
   localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(READY_DIVIDER - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t             r_state;
   logic               r_tready;
   logic [C_DIV_W-1:0] r_div;
   logic [C_W-1:0]     r_expected;
   logic               w_beat;
   logic [C_DIV_W-1:0] w_div_next;
   logic [C_W-1:0]     w_exp_on_miss;

   // Extra bit keeps x+INCR from wrapping before the END comparison.
   function automatic logic [C_W-1:0] next_val(input logic [C_W-1:0] x);
      logic [C_W:0] sum;
      sum = {1'b0, x} + C_INCR_EXT;
      if (sum > C_END_EXT)
         return C_START;
      else
         return sum[C_W-1:0];
   endfunction

   assign s_axis.tready = r_tready;
   assign w_beat        = s_axis.tvalid & r_tready;
   assign w_div_next    = (r_div == C_DIV_LAST) ? '0 : r_div + C_DIV_W'(1);

`ifdef AXIS_TPCHK_RESYNC_EN
   assign w_exp_on_miss = next_val(s_axis.tdata);
`else
   assign w_exp_on_miss = next_val(r_expected);
`endif

   always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
      if (s_axis_areset) begin
         r_state    <= ST_IDLE;
         r_tready   <= 1'b0;
         r_div      <= '0;
         r_expected <= C_START;
         locked     <= 1'b0;
         error      <= 1'b0;
         err_count  <= '0;
         beat_count <= '0;
      end else if (!enable) begin
         r_state  <= ST_IDLE;
         r_tready <= 1'b0;
         r_div    <= '0;
         locked   <= 1'b0;
         if (clear) begin
            error      <= 1'b0;
            err_count  <= '0;
            beat_count <= '0;
         end
      end else if (clear) begin
         // A beat coinciding with clear is dropped; re-lock from scratch.
         r_state    <= ST_SYNC;
         r_tready   <= 1'b1;
         r_div      <= '0;
         locked     <= 1'b0;
         error      <= 1'b0;
         err_count  <= '0;
         beat_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state  <= ST_SYNC;
               r_tready <= 1'b1;
               r_div    <= '0;
            end
            ST_SYNC: begin
               r_div    <= w_div_next;
               r_tready <= (w_div_next == '0);
               if (w_beat && (s_axis.tdata == C_START)) begin
                  r_state    <= ST_LOCKED;
                  locked     <= 1'b1;
                  r_expected <= next_val(C_START);
                  beat_count <= beat_count + BEATCNT_WIDTH'(1);
               end
            end
            ST_LOCKED: begin
               r_div    <= w_div_next;
               r_tready <= (w_div_next == '0);
               if (w_beat) begin
                  beat_count <= beat_count + BEATCNT_WIDTH'(1);
                  if (s_axis.tdata == r_expected) begin
                     r_expected <= next_val(r_expected);
                  end else begin
                     error      <= 1'b1;
                     r_expected <= w_exp_on_miss;
                     if (err_count != '1)
                        err_count <= err_count + ERRCNT_WIDTH'(1);
                  end
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_tready <= 1'b0;
               locked   <= 1'b0;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_axis_testpattern_checker.sv
`default_nettype none
// ============================================================================
// tb_axis_testpattern_checker : directed vector bench for the pattern checker
// Revision: 1.0
// ============================================================================
module tb_axis_testpattern_checker;
`ifdef AXIS_TPCHK_RESYNC_EN
   localparam bit RS = 1'b1;
`else
   localparam bit RS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        en_a = 1'b0, clr_a = 1'b0;
   logic        lock_a, err_a;
   logic [3:0]  ec_a;
   logic [31:0] bc_a;
   logic        en_b = 1'b0, clr_b = 1'b0;
   logic        lock_b, err_b;
   logic [15:0] ec_b;
   logic [31:0] bc_b;

   axis_testpattern_checker_if #(.TDATA_WIDTH(32)) ifa ();
   axis_testpattern_checker_if #(.TDATA_WIDTH(32)) ifb ();

   axis_testpattern_checker #(
      .S00_AXIS_TDATA_WIDTH(32), .COUNTER_START(1), .COUNTER_END(10),
      .COUNTER_INCR(1), .READY_DIVIDER(1), .ERRCNT_WIDTH(4), .BEATCNT_WIDTH(32)
   ) dut_a (
      .s_axis_aclk(clk), .s_axis_areset(rst), .enable(en_a), .clear(clr_a),
      .s_axis(ifa.slave), .locked(lock_a), .error(err_a),
      .err_count(ec_a), .beat_count(bc_a)
   );

   axis_testpattern_checker #(
      .S00_AXIS_TDATA_WIDTH(32), .COUNTER_START(1), .COUNTER_END(10),
      .COUNTER_INCR(1), .READY_DIVIDER(3), .ERRCNT_WIDTH(16), .BEATCNT_WIDTH(32)
   ) dut_b (
      .s_axis_aclk(clk), .s_axis_areset(rst), .enable(en_b), .clear(clr_b),
      .s_axis(ifb.slave), .locked(lock_b), .error(err_b),
      .err_count(ec_b), .beat_count(bc_b)
   );

   typedef struct {
      logic        en;
      logic        clr;
      logic        vld;
      logic [31:0] data;
      logic        x_rdy;
      logic        x_lock;
      logic        x_err;
      logic [3:0]  x_ec;
      logic [31:0] x_bc;
   } vec_t;

   vec_t vecs[$];
   int   compared   = 0;
   int   mismatched = 0;

   task automatic add(input logic en, input logic clr, input logic vld, input int data,
                      input logic rdy, input logic lk, input logic er, input int ec, input int bc);
      vec_t v;
      v.en = en; v.clr = clr; v.vld = vld; v.data = 32'(data);
      v.x_rdy = rdy; v.x_lock = lk; v.x_err = er; v.x_ec = 4'(ec); v.x_bc = 32'(bc);
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int bt;
      logic rdy_s;
      logic [31:0] dat_b;

      ifa.tvalid = 1'b0; ifa.tdata = '0;
      ifb.tvalid = 1'b0; ifb.tdata = '0;

      // enable, then clean stream 1..10,1,2
      add(1,0,0,0, 1,0,0,0,0);
      for (int v = 1; v <= 10; v++) add(1,0,1,v, 1,1,0,0,v);
      add(1,0,1,1, 1,1,0,0,11);
      add(1,0,1,2, 1,1,0,0,12);
      // clear on a beat, stream joins at 5, then locks on 1
      add(1,1,1,3, 1,0,0,0,0);
      for (int v = 5; v <= 10; v++) add(1,0,1,v, 1,0,0,0,0);
      for (int v = 1; v <= 10; v++) add(1,0,1,v, 1,1,0,0,v);
      // dropped beat: 1,2,3,5,6,7,8
      for (int v = 1; v <= 3; v++) add(1,0,1,v, 1,1,0,0,10+v);
      for (int j = 0; j < 4; j++) add(1,0,1,5+j, 1,1,1, RS ? 1 : j+1, 14+j);
      // clear mid-stream, re-lock, then enable dropped for 5 cycles
      add(1,1,1,9, 1,0,0,0,0);
      for (int v = 1; v <= 3; v++) add(1,0,1,v, 1,1,0,0,v);
      for (int j = 0; j < 5; j++) add(0,0,0,4, 0,0,0,0,3);
      add(1,0,0,0, 1,0,0,0,3);
      add(1,0,1,5, 1,0,0,0,3);
      add(1,0,1,1, 1,1,0,0,4);
      add(1,0,1,2, 1,1,0,0,5);
      // 20 mismatching beats, err_count saturates at 15
      for (int k = 1; k <= 20; k++) add(1,0,1,0, 1,1,1, (k > 15) ? 15 : k, 5+k);

      #2;
      chk("reset.tready", 32'(ifa.tready), 0);
      chk("reset.locked", 32'(lock_a), 0);
      chk("reset.error",  32'(err_a), 0);
      chk("reset.errcnt", 32'(ec_a), 0);
      chk("reset.beatcnt", bc_a, 0);
      chk("reset.b_tready", 32'(ifb.tready), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         en_a = vecs[i].en; clr_a = vecs[i].clr;
         ifa.tvalid = vecs[i].vld; ifa.tdata = vecs[i].data;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d.tready", i),  32'(ifa.tready), 32'(vecs[i].x_rdy));
         chk($sformatf("v%0d.locked", i),  32'(lock_a),     32'(vecs[i].x_lock));
         chk($sformatf("v%0d.error", i),   32'(err_a),      32'(vecs[i].x_err));
         chk($sformatf("v%0d.errcnt", i),  32'(ec_a),       32'(vecs[i].x_ec));
         chk($sformatf("v%0d.beatcnt", i), bc_a,            vecs[i].x_bc);
      end
      en_a = 1'b0; ifa.tvalid = 1'b0;

      // divide-by-3 backpressure with an always-valid source
      en_b = 1'b1; ifb.tvalid = 1'b1; dat_b = 32'd1; ifb.tdata = dat_b;
      @(posedge clk);
      #1;
      bt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         rdy_s = ifb.tready;
         chk($sformatf("b%0d.tready", i), 32'(rdy_s), (i % 3 == 0) ? 32'd1 : 32'd0);
         @(posedge clk);
         #1;
         if (rdy_s) begin
            bt++;
            dat_b = (dat_b == 32'd10) ? 32'd1 : dat_b + 32'd1;
            ifb.tdata = dat_b;
         end
      end
      chk("b.beats_seen", 32'(bt), 10);
      chk("b.beatcnt", bc_b, 10);
      chk("b.locked", 32'(lock_b), 1);
      chk("b.errcnt", 32'(ec_b), 0);
      chk("b.error", 32'(err_b), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
`default_nettype wire
